data_mem_arbiter: RTL and testbench
===================================

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and reset: clk, reset synchronous active-low rst_n; every flop updates only on posedge clk.
REQ-002 Parameter ADDR_W SHALL default to 8 and set the data-bus address width.
REQ-003 Parameter DATA_W SHALL default to 8 and set the data-bus data width.
REQ-004 Parameter TIMEOUT SHALL default to 16 and give the maximum wait-for-ack cycles, legal range 2..255.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst_n  in  1  sync active-low reset
- mX_cyc_i, mX_stb_i, mX_we_i  in  1 each  master X bus cycle / strobe / write (X = 0 CPU core, 1 DMA)
- mX_adr_i  in  ADDR_W  address
- mX_dat_i  in  DATA_W  write data
- mX_dat_o  out  DATA_W  read data
- mX_ack_o  out  1  acknowledge
- mX_err_o  out  1  timeout error
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side cycle / strobe / write
- s_adr_o  out  ADDR_W  slave address
- s_dat_o  out  DATA_W  slave write data
- s_dat_i  in  DATA_W  slave read data
- s_ack_i  in  1  slave acknowledge
- gnt_o  out  2  one-hot owner, bit X = master X

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, OWN_M0, OWN_M1.
REQ-007 A request SHALL be mX_cyc_i & mX_stb_i.
REQ-008 In IDLE with one request, the FSM SHALL enter OWN_mX on the next edge.
REQ-009 In IDLE with both requesting, the FSM SHALL grant the master not recorded in last_grant (round-robin).
REQ-010 last_grant SHALL update on every grant.
REQ-011 In OWN_mX, the slave outputs SHALL combinationally follow master X: s_cyc_o=mX_cyc_i, s_stb_o=mX_stb_i, and we/adr/dat likewise.
REQ-012 In OWN_mX, mX_ack_o SHALL equal s_ack_i and mX_dat_o SHALL equal s_dat_i.
REQ-013 The non-owner's ack, err and dat_o SHALL be 0.
REQ-014 In IDLE, all s_* outputs SHALL be 0 and s_ack_i SHALL be ignored.
REQ-015 Grant latency SHALL be: request first seen at edge N, slave strobe visible in cycle N+1; first ack no earlier than cycle N+1.
REQ-016 The owner SHALL keep the bus across multiple strobes while mX_cyc_i stays high.
REQ-017 The FSM SHALL return to IDLE on the edge where the owner's cyc_i is low.
REQ-018 There SHALL be no direct OWN_M0<->OWN_M1 transition; at least one IDLE cycle separates owners.
REQ-019 The watchdog counter SHALL increment each owned cycle with s_stb_o=1 and s_ack_i=0, and SHALL clear on ack or in IDLE.
REQ-020 When the counter equals TIMEOUT-1 with no ack, the block SHALL, in that same cycle, assert mX_err_o, force s_cyc_o/s_stb_o to 0, and go to IDLE at the next edge; err lasts exactly one cycle.
REQ-021 If ack and timeout coincide, ack SHALL win and err stays 0.
REQ-022 gnt_o SHALL be 2'b00 in IDLE, 2'b01 in OWN_M0, and 2'b10 in OWN_M1.

Reset
REQ-023 rst_n=0 at an edge SHALL set state=IDLE, counter=0, last_grant=M1 (M0 wins the first tie), regardless of any transaction in flight.
REQ-024 In the cycle after that reset edge, all outputs SHALL be 0.

Structure
REQ-025 A shared package SHALL hold the state enum (arb_state_t), master index constants M0/M1, and bus width defaults.
REQ-026 One sub-module, arb_watchdog (counter plus timeout compare), is natural; all other logic SHALL stay flat.

Verification
REQ-027 The bench SHALL cover at least these five directed scenarios:
- Single M0 read, adr 8'h12, ack after 2 wait cycles, s_dat_i=8'hA5 -> m0_dat_o=8'hA5 with m0_ack_o; gnt_o=01; m1 sees 0.
- Both request in the same cycle after reset -> M0 granted; after M0 drops cyc, one IDLE cycle, then M1 granted; repeat tie -> M0 again.
- M1 write burst of 3 strobes under one cyc, adr 10/11/12, dat 1/2/3 -> s_we_o=1 with matching adr/dat each ack; M0 request held off, no M0 ack.
- Slave never acks with TIMEOUT=16 -> m0_err_o pulses exactly 1 cycle in the 16th strobe cycle, s_cyc_o drops, state IDLE.
- ack in the timeout cycle -> ack delivered, err 0; rst_n low mid-transaction -> all outputs 0 next cycle, next tie goes to M0.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the two-master data-memory arbiter.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ADDR_W_DEF  = 8;
  localparam int DATA_W_DEF  = 8;
  localparam int TIMEOUT_DEF = 16;
  localparam int WDOG_W      = 8;

  typedef struct packed {
    logic cyc;
    logic stb;
    logic we;
  } bus_ctl_t;

endpackage

// File: rtl/data_mem_arbiter_watchdog.sv
// Wait-for-ack watchdog: counts unacknowledged strobe cycles of the owner.
module arb_watchdog
  import data_mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic owned,
  input  logic stb,
  input  logic ack,
  output logic tmo
);

  logic [WDOG_W-1:0] cnt;
  logic              inc;

  assign inc = owned & stb & ~ack;
  // Uses the master's raw strobe so forcing s_stb_o low cannot feed back here.
  assign tmo = inc & (cnt == WDOG_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (!owned || ack)  cnt <= '0;
    else if (inc)            cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-master (CPU core, DMA) round-robin arbiter onto a single data-memory slave.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  arb_state_t state, state_nxt;
  logic       last_grant, last_grant_nxt;
  logic       req0, req1;
  logic       owned, own_cyc, own_stb, ack, tmo;
  bus_ctl_t   ctl;

  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= M1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_grant == M1)) begin
          state_nxt      = OWN_M0;
          last_grant_nxt = M0;
        end else if (req1) begin
          state_nxt      = OWN_M1;
          last_grant_nxt = M1;
        end
      end
      OWN_M0:  if (!m0_cyc_i || tmo) state_nxt = IDLE;
      OWN_M1:  if (!m1_cyc_i || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign owned = (state == OWN_M0) || (state == OWN_M1);
  assign ack   = owned & s_ack_i;

  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    gnt_o   = 2'b00;
    case (state)
      OWN_M0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        s_we_o  = m0_we_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        gnt_o   = 2'b01;
      end
      OWN_M1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        s_we_o  = m1_we_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        gnt_o   = 2'b10;
      end
      default: ;
    endcase
  end

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .owned (owned),
    .stb   (own_stb),
    .ack   (s_ack_i),
    .tmo   (tmo)
  );

  // A timed-out owner loses the slave in the same cycle its error is flagged.
  assign ctl     = '{cyc: own_cyc & ~tmo, stb: own_stb & ~tmo, we: s_we_o};
  assign s_cyc_o = ctl.cyc;
  assign s_stb_o = ctl.stb;

  assign m0_ack_o = (state == OWN_M0) & ack;
  assign m1_ack_o = (state == OWN_M1) & ack;
  assign m0_err_o = (state == OWN_M0) & tmo;
  assign m1_err_o = (state == OWN_M1) & tmo;
  assign m0_dat_o = (state == OWN_M0) ? s_dat_i : '0;
  assign m1_dat_o = (state == OWN_M1) ? s_dat_i : '0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with default parameters.
module tb_data_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_cyc_i, m0_stb_i, m0_we_i;
  logic [7:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic       m0_ack_o, m0_err_o;
  logic       m1_cyc_i, m1_stb_i, m1_we_i;
  logic [7:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic       m1_ack_o, m1_err_o;
  logic       s_cyc_o, s_stb_o, s_we_o;
  logic [7:0] s_adr_o, s_dat_o, s_dat_i;
  logic       s_ack_i;
  logic [1:0] gnt_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  wire [40:0] all_o = {m0_dat_o, m0_ack_o, m0_err_o, m1_dat_o, m1_ack_o, m1_err_o,
                       s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, gnt_o};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_req(input logic on, input logic we, input logic [7:0] adr);
    m0_cyc_i = on; m0_stb_i = on; m0_we_i = we; m0_adr_i = adr;
  endtask

  task automatic m1_req(input logic on, input logic we, input logic [7:0] adr, input logic [7:0] dat);
    m1_cyc_i = on; m1_stb_i = on; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req(0, 0, 8'h00); m0_dat_i = 8'h00;
    m1_req(0, 0, 8'h00, 8'h00);
    s_dat_i = 8'h00; s_ack_i = 1'b0;
    tick(); tick();
    rst_n = 1'b1; s_ack_i = 1'b1; s_dat_i = 8'h77;
    #1;
    chk("reset_all_zero", 64'(all_o), 64'h0);
    s_ack_i = 1'b0; s_dat_i = 8'h00;

    // Single M0 read, 2 wait cycles, then ack with A5
    m0_req(1, 0, 8'h12);
    #1; chk("s1_idle_gnt", 64'(gnt_o), 64'h0);
    chk("s1_idle_stb", 64'(s_stb_o), 64'h0);
    tick(); #1;
    chk("s1_gnt", 64'(gnt_o), 64'h1);
    chk("s1_stb", 64'(s_stb_o), 64'h1);
    chk("s1_adr", 64'(s_adr_o), 64'h12);
    chk("s1_wait1_ack", 64'(m0_ack_o), 64'h0);
    tick(); #1;
    chk("s1_wait2_ack", 64'(m0_ack_o), 64'h0);
    tick(); s_ack_i = 1'b1; s_dat_i = 8'hA5; #1;
    chk("s1_dat", 64'(m0_dat_o), 64'hA5);
    chk("s1_ack", 64'(m0_ack_o), 64'h1);
    chk("s1_m1_quiet", 64'({m1_dat_o, m1_ack_o, m1_err_o}), 64'h0);
    tick(); s_ack_i = 1'b0; s_dat_i = 8'h00; m0_req(0, 0, 8'h00); #1;
    chk("s1_hold_till_edge", 64'(gnt_o), 64'h1);
    tick(); #1;
    chk("s1_back_idle", 64'(gnt_o), 64'h0);

    // Tie after reset goes to M0, then M1, then M0
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m0_req(1, 0, 8'h20); m1_req(1, 0, 8'h30, 8'h00);
    tick(); s_ack_i = 1'b1; #1;
    chk("s2_tie1_gnt", 64'(gnt_o), 64'h1);
    chk("s2_tie1_acks", 64'({m0_ack_o, m1_ack_o}), 64'h2);
    tick(); s_ack_i = 1'b0; m0_req(0, 0, 8'h00); #1;
    chk("s2_m0_drop", 64'(gnt_o), 64'h1);
    tick(); #1;
    chk("s2_gap_idle", 64'(gnt_o), 64'h0);
    tick(); #1;
    chk("s2_m1_gnt", 64'(gnt_o), 64'h2);
    chk("s2_m1_adr", 64'(s_adr_o), 64'h30);
    tick(); m1_req(0, 0, 8'h00, 8'h00); #1;
    tick(); m0_req(1, 0, 8'h21); m1_req(1, 0, 8'h31, 8'h00); #1;
    chk("s2_gap2_idle", 64'(gnt_o), 64'h0);
    tick(); #1;
    chk("s2_tie2_gnt", 64'(gnt_o), 64'h1);
    tick(); m0_req(0, 0, 8'h00); m1_req(0, 0, 8'h00, 8'h00);
    tick(); #1;
    chk("s2_end_idle", 64'(gnt_o), 64'h0);

    // M1 write burst, M0 held off (last grant was M0)
    m1_req(1, 1, 8'd10, 8'd1); m0_req(1, 0, 8'h40);
    tick(); s_ack_i = 1'b1; #1;
    chk("s3_gnt", 64'(gnt_o), 64'h2);
    chk("s3_b0", 64'({s_we_o, s_adr_o, s_dat_o, m1_ack_o, m0_ack_o}), 64'({1'b1, 8'd10, 8'd1, 1'b1, 1'b0}));
    tick(); m1_adr_i = 8'd11; m1_dat_i = 8'd2; #1;
    chk("s3_b1", 64'({s_we_o, s_adr_o, s_dat_o, m1_ack_o, m0_ack_o}), 64'({1'b1, 8'd11, 8'd2, 1'b1, 1'b0}));
    tick(); m1_adr_i = 8'd12; m1_dat_i = 8'd3; #1;
    chk("s3_b2", 64'({s_we_o, s_adr_o, s_dat_o, m1_ack_o, m0_ack_o}), 64'({1'b1, 8'd12, 8'd3, 1'b1, 1'b0}));
    tick(); s_ack_i = 1'b0; m1_req(0, 0, 8'h00, 8'h00); #1;
    chk("s3_drop_gnt", 64'({gnt_o, m0_ack_o}), 64'({2'b10, 1'b0}));
    tick(); #1;
    chk("s3_gap_idle", 64'(gnt_o), 64'h0);
    tick(); #1;
    chk("s3_m0_after", 64'(gnt_o), 64'h1);
    tick(); m0_req(0, 0, 8'h00);
    tick(); #1;
    chk("s3_end_idle", 64'(gnt_o), 64'h0);

    // Slave never acks: error in the 16th strobe cycle
    m0_req(1, 0, 8'h55);
    tick(); #1;
    for (int k = 1; k < 16; k++) begin
      chk($sformatf("s4_noerr_%0d", k), 64'({m0_err_o, s_cyc_o}), 64'h1);
      tick(); #1;
    end
    chk("s4_err", 64'({m0_err_o, m1_err_o, s_cyc_o, s_stb_o, gnt_o}), 64'({1'b1, 1'b0, 1'b0, 1'b0, 2'b01}));
    tick(); m0_req(0, 0, 8'h00); #1;
    chk("s4_idle", 64'({gnt_o, m0_err_o}), 64'h0);
    tick();

    // Ack arriving in the timeout cycle wins
    m0_req(1, 0, 8'h66);
    tick(); #1;
    for (int k = 1; k < 16; k++) tick();
    s_ack_i = 1'b1; s_dat_i = 8'h3C; #1;
    chk("s5_ack_wins", 64'({m0_ack_o, m0_err_o, s_cyc_o, m0_dat_o}), 64'({1'b1, 1'b0, 1'b1, 8'h3C}));
    tick(); s_ack_i = 1'b0; s_dat_i = 8'h00; #1;
    chk("s5_still_owned", 64'({gnt_o, m0_err_o}), 64'({2'b01, 1'b0}));

    // Reset mid-transaction while M0 owns (last grant M0) and M1 waits
    m1_req(1, 0, 8'h70, 8'h00); rst_n = 1'b0;
    tick(); #1;
    chk("s5_rst_zero", 64'(all_o), 64'h0);
    rst_n = 1'b1;
    tick(); #1;
    chk("s5_post_rst_tie", 64'(gnt_o), 64'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
